// File: rtl/strobe_period_meter.sv
// Strobe period meter: counts Clock cycles between rising edges of Strobe_i,
// reports each completed period with a one-cycle Valid_o pulse, flags lock when
// consecutive periods agree within TOLERANCE, and flags timeout when strobes stop.
module strobe_period_meter #(
  parameter int unsigned CLOCK_HZ  = 10_000_000,
  parameter int unsigned MAX_TICKS = 65535,
  parameter int unsigned TOLERANCE = 1,
  localparam int unsigned WIDTH    = $clog2(MAX_TICKS + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable_i,
  input  logic             Strobe_i,
  output logic [WIDTH-1:0] Period_o,
  output logic             Valid_o,
  output logic             Locked_o,
  output logic             Timeout_o
);

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_TICKS);
  localparam logic [WIDTH:0]   TolW   = (WIDTH + 1)'(TOLERANCE);

  // Reject meaningless configurations at elaboration.
  if (CLOCK_HZ == 0 || MAX_TICKS == 0) begin : g_bad_param
    $error("strobe_period_meter: CLOCK_HZ and MAX_TICKS must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StTimeout} state_e;

  state_e           r_state_q, w_state_d;
  logic [WIDTH-1:0] r_cnt_q, w_cnt_d;
  logic [WIDTH-1:0] r_prev_q, w_prev_d;
  logic             r_have_prev_q, w_have_prev_d;
  logic [WIDTH-1:0] r_period_q, w_period_d;
  logic             r_valid_q, w_valid_d;
  logic             r_locked_q, w_locked_d;
  logic             r_timeout_q, w_timeout_d;
  logic             r_strobe_q;

  logic             w_edge;
  logic [WIDTH:0]   w_diff;
  logic             w_in_tol;

  assign w_edge = Strobe_i & ~r_strobe_q;

  // Absolute difference between the period just completed and the previous one.
  always_comb begin
    if (r_cnt_q >= r_prev_q) begin
      w_diff = {1'b0, r_cnt_q} - {1'b0, r_prev_q};
    end else begin
      w_diff = {1'b0, r_prev_q} - {1'b0, r_cnt_q};
    end
    w_in_tol = (w_diff <= TolW);
  end

  // Next-state and registered-output logic; disable overrides every state.
  always_comb begin
    w_state_d     = r_state_q;
    w_cnt_d       = r_cnt_q;
    w_prev_d      = r_prev_q;
    w_have_prev_d = r_have_prev_q;
    w_period_d    = r_period_q;
    w_valid_d     = 1'b0;
    w_locked_d    = r_locked_q;
    w_timeout_d   = r_timeout_q;

    if (!Enable_i) begin
      w_state_d     = StIdle;
      w_cnt_d       = '0;
      w_have_prev_d = 1'b0;
      w_locked_d    = 1'b0;
      w_timeout_d   = 1'b0;
    end else begin
      unique case (r_state_q)
        StIdle: begin
          // Edges are not looked at here; Strobe_q has been tracking, so a
          // strobe already high when enabled is not mistaken for an edge.
          w_state_d     = StArm;
          w_cnt_d       = '0;
          w_have_prev_d = 1'b0;
          w_locked_d    = 1'b0;
          w_timeout_d   = 1'b0;
        end
        StArm: begin
          w_have_prev_d = 1'b0;
          if (w_edge) begin
            w_cnt_d   = WIDTH'(1);
            w_state_d = StMeasure;
          end
        end
        StMeasure: begin
          if (w_edge) begin
            // Edge wins even when the counter has just reached MaxCnt.
            w_period_d    = r_cnt_q;
            w_valid_d     = 1'b1;
            w_locked_d    = r_have_prev_q & w_in_tol;
            w_prev_d      = r_cnt_q;
            w_have_prev_d = 1'b1;
            w_cnt_d       = WIDTH'(1);
          end else if (r_cnt_q == MaxCnt) begin
            w_state_d     = StTimeout;
            w_timeout_d   = 1'b1;
            w_locked_d    = 1'b0;
            w_have_prev_d = 1'b0;
          end else begin
            w_cnt_d = r_cnt_q + WIDTH'(1);
          end
        end
        StTimeout: begin
          // Counter frozen; the next edge restarts without a period report.
          w_have_prev_d = 1'b0;
          if (w_edge) begin
            w_cnt_d     = WIDTH'(1);
            w_timeout_d = 1'b0;
            w_state_d   = StMeasure;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state_q     <= StIdle;
      r_cnt_q       <= '0;
      r_prev_q      <= '0;
      r_have_prev_q <= 1'b0;
      r_period_q    <= '0;
      r_valid_q     <= 1'b0;
      r_locked_q    <= 1'b0;
      r_timeout_q   <= 1'b0;
      r_strobe_q    <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_cnt_q       <= w_cnt_d;
      r_prev_q      <= w_prev_d;
      r_have_prev_q <= w_have_prev_d;
      r_period_q    <= w_period_d;
      r_valid_q     <= w_valid_d;
      r_locked_q    <= w_locked_d;
      r_timeout_q   <= w_timeout_d;
      r_strobe_q    <= Strobe_i;
    end
  end

  assign Period_o  = r_period_q;
  assign Valid_o   = r_valid_q;
  assign Locked_o  = r_locked_q;
  assign Timeout_o = r_timeout_q;

endmodule

// File: tb/tb_strobe_period_meter.sv
// Bench for strobe_period_meter: directed and random strobe trains checked every
// cycle against a timestamp-based model of the period/lock/timeout rules.
`timescale 1ns/1ps
module tb_strobe_period_meter;

  localparam int unsigned MaxT  = 50;
  localparam int unsigned Tol   = 1;
  localparam int unsigned Width = $clog2(MaxT + 1);

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Enable_i = 1'b0;
  logic             Strobe_i = 1'b0;
  logic [Width-1:0] Period_o;
  logic             Valid_o;
  logic             Locked_o;
  logic             Timeout_o;

  int total = 0;
  int bad   = 0;

  // Model: absolute cycle index of the last accepted edge and the last period.
  int m_cyc;
  int m_last;      // -1: no edge since arming
  int m_prev;      // -1: no previous period for lock comparison
  int m_run;       // consecutive enabled cycles seen (0 or 1 is enough)
  logic m_sprev;
  int m_period;
  logic m_valid, m_locked, m_tout;

  strobe_period_meter #(
    .CLOCK_HZ (10_000_000),
    .MAX_TICKS(MaxT),
    .TOLERANCE(Tol)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable_i (Enable_i),
    .Strobe_i (Strobe_i),
    .Period_o (Period_o),
    .Valid_o  (Valid_o),
    .Locked_o (Locked_o),
    .Timeout_o(Timeout_o)
  );

  always #50 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".period"},  32'(Period_o), 32'(m_period));
    check({tag, ".valid"},   32'(Valid_o), 32'(m_valid));
    check({tag, ".locked"},  32'(Locked_o), 32'(m_locked));
    check({tag, ".timeout"}, 32'(Timeout_o), 32'(m_tout));
  endtask

  task automatic model_reset();
    m_cyc = 0; m_last = -1; m_prev = -1; m_run = 0; m_sprev = 1'b0;
    m_period = 0; m_valid = 1'b0; m_locked = 1'b0; m_tout = 1'b0;
  endtask

  task automatic model_tick(input logic s, input logic e);
    logic edge_seen;
    int p, d;
    edge_seen = s && !m_sprev;
    m_sprev = s;
    m_cyc++;
    m_valid = 1'b0;
    if (!e) begin
      m_run = 0; m_last = -1; m_prev = -1; m_locked = 1'b0; m_tout = 1'b0;
    end else if (m_run == 0) begin
      m_run = 1;  // first enabled cycle only arms
    end else if (edge_seen) begin
      if (m_last >= 0 && !m_tout) begin
        p = m_cyc - m_last;
        d = (p > m_prev) ? p - m_prev : m_prev - p;
        m_period = p;
        m_valid  = 1'b1;
        m_locked = (m_prev >= 0) && (d <= int'(Tol));
        m_prev   = p;
      end else begin
        m_tout = 1'b0;
        m_prev = -1;
      end
      m_last = m_cyc;
    end else if (m_last >= 0 && !m_tout && (m_cyc - m_last) == int'(MaxT)) begin
      m_tout = 1'b1; m_locked = 1'b0; m_prev = -1;
    end
  endtask

  task automatic step(input logic s, input logic e, input string tag);
    Strobe_i = s;
    Enable_i = e;
    @(posedge Clock);
    model_tick(s, e);
    #1;
    check_all(tag);
  endtask

  // One strobe of the given high width, then low for the rest of the gap.
  task automatic pulse(input int gap, input int width, input string tag);
    for (int i = 0; i < gap; i++) step(i < width, 1'b1, tag);
  endtask

  task automatic lows(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, tag);
  endtask

  initial begin
    int g, w;
    int held;
    model_reset();
    Reset = 1'b1;
    #120;
    check_all("reset");
    @(negedge Clock);
    Reset = 1'b0;

    // Steady 10-cycle strobes: first edge arms, second reports, then lock.
    step(1'b0, 1'b1, "arm");
    for (int k = 0; k < 6; k++) pulse(10, 1, "steady");
    check("steady.period_const", 32'(Period_o), 32'd10);
    check("steady.locked_const", 32'(Locked_o), 32'd1);

    // Jitter from a fresh arm: 10, 11, 13.
    step(1'b0, 1'b0, "jit.dis");
    step(1'b0, 1'b1, "jit.idle");
    pulse(10, 1, "jit1");
    pulse(11, 1, "jit2");
    check("jit.p10", 32'(Period_o), 32'd10);
    check("jit.l10", 32'(Locked_o), 32'd0);
    pulse(13, 1, "jit3");
    check("jit.p11", 32'(Period_o), 32'd11);
    check("jit.l11", 32'(Locked_o), 32'd1);
    pulse(10, 1, "jit4");
    check("jit.p13", 32'(Period_o), 32'd13);
    check("jit.l13", 32'(Locked_o), 32'd0);

    // Lock, then strobes stop: timeout exactly MaxT cycles after the last edge.
    pulse(10, 1, "lk"); pulse(10, 1, "lk");
    step(1'b1, 1'b1, "last_edge");
    lows(MaxT - 1, "pre_to");
    check("to.not_yet", 32'(Timeout_o), 32'd0);
    step(1'b0, 1'b1, "to_hit");
    check("to.set", 32'(Timeout_o), 32'd1);
    check("to.unlock", 32'(Locked_o), 32'd0);
    lows(5, "to_hold");
    step(1'b1, 1'b1, "to_clear");
    check("to.cleared", 32'(Timeout_o), 32'd0);
    check("to.no_valid", 32'(Valid_o), 32'd0);
    lows(9, "after_to");
    step(1'b1, 1'b1, "first_after_to");
    check("to.valid", 32'(Valid_o), 32'd1);
    check("to.nolock", 32'(Locked_o), 32'd0);

    // Boundary: gap of exactly MaxT reports, gap of MaxT+1 times out.
    lows(MaxT - 1, "gap50");
    step(1'b1, 1'b1, "edge50");
    check("b50.valid", 32'(Valid_o), 32'd1);
    check("b50.period", 32'(Period_o), 32'(MaxT));
    check("b50.timeout", 32'(Timeout_o), 32'd0);
    lows(MaxT, "gap51");
    step(1'b1, 1'b1, "edge51");
    check("b51.no_valid", 32'(Valid_o), 32'd0);

    // Disable for 5 cycles starting on an edge cycle.
    lows(9, "pre_dis");
    pulse(10, 1, "pre_dis2");
    held = m_period;
    step(1'b1, 1'b0, "dis_edge");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "dis");
    check("dis.period_held", 32'(Period_o), 32'(held));
    step(1'b0, 1'b1, "reen");
    pulse(10, 1, "reen1");
    check("dis.first_no_valid", 32'(Valid_o), 32'd0);
    pulse(10, 1, "reen2");

    // Random strobe trains with occasional disables.
    for (int k = 0; k < 40; k++) begin
      g = int'($urandom_range(2, 56));
      w = int'($urandom_range(1, g - 1));
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 4)); i++)
          step(1'(($urandom_range(0, 1))), 1'b0, "rnd.dis");
      end
      pulse(g, w, "rnd");
    end

    // Asynchronous reset mid-period with strobe held high across release.
    pulse(10, 1, "pre_rst");
    step(1'b0, 1'b1, "pre_rst2");
    Strobe_i = 1'b1;
    #30;
    Reset = 1'b1;
    #1;
    model_reset();
    m_sprev = 1'b0;
    check_all("async_rst");
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "held_high");
    step(1'b0, 1'b1, "toggle_low");
    pulse(10, 1, "post_rst1");
    pulse(10, 1, "post_rst2");
    check("rst.period", 32'(Period_o), 32'd10);
    check("rst.nolock", 32'(Locked_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog expired observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
